mole_game_fsm: RTL and testbench

Game-control stage of the whack-a-mole design, directly downstream of the LED-rate clock divider. It takes the divider's slow toggling output as its step timebase, picks a pseudo-random mole LED each round, and judges button presses as hit or miss. It maintains the score, lives and game-over status that drive the LEDs and display logic.

---
 rtl/mole_game_fsm.sv | 148 ++++++++++++++
 tb/tb_mole_game_fsm.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_game_fsm.sv
// Whack-a-mole game control: conditions the raw inputs, picks a pseudo-random
// mole each round and judges button presses, keeping score, lives and status.
module mole_game_fsm #(
  parameter int unsigned N_MOLES   = 4,
  parameter int unsigned UP_STEPS  = 2,
  parameter int unsigned LIVES     = 3,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               step_clk,
  input  logic               start,
  input  logic [N_MOLES-1:0] btn,
  output logic [N_MOLES-1:0] led,
  output logic [7:0]         score,
  output logic [1:0]         lives,
  output logic               active,
  output logic               game_over
);

  localparam int unsigned IDX_W = (N_MOLES > 1) ? $clog2(N_MOLES) : 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {S_IDLE, S_GAP, S_PICK, S_UP, S_OVER} state_t;

  state_t             state;
  logic [2:0]         step_s;
  logic [2:0]         start_s;
  logic [N_MOLES-1:0] btn_s1;
  logic [N_MOLES-1:0] btn_s2;
  logic [N_MOLES-1:0] btn_s3;
  logic               step_ev;
  logic               start_ev;
  logic [N_MOLES-1:0] press;
  logic [7:0]         lfsr;
  logic [IDX_W-1:0]   prev_idx;
  logic [CNT_W-1:0]   up_cnt;

  logic [IDX_W-1:0]   raw_idx;
  logic [IDX_W-1:0]   pick_idx;
  logic [N_MOLES-1:0] pick_mask;
  logic [N_MOLES-1:0] mole_mask;
  logic               wrong;
  logic               hit;
  logic               timeout;

  // Two-flop synchronizers followed by registered edge detectors.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      step_s   <= '0;
      start_s  <= '0;
      btn_s1   <= '0;
      btn_s2   <= '0;
      btn_s3   <= '0;
      step_ev  <= 1'b0;
      start_ev <= 1'b0;
      press    <= '0;
    end else begin
      step_s   <= {step_s[1:0], step_clk};
      start_s  <= {start_s[1:0], start};
      btn_s1   <= btn;
      btn_s2   <= btn_s1;
      btn_s3   <= btn_s2;
      step_ev  <= step_s[1] ^ step_s[2];
      start_ev <= start_s[1] & ~start_s[2];
      press    <= btn_s2 & ~btn_s3;
    end
  end

  // Free-running Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  // Mole selection (never repeats the previous mole) and press judging terms.
  always_comb begin
    raw_idx   = lfsr[IDX_W-1:0];
    pick_idx  = (raw_idx == prev_idx) ? raw_idx + IDX_W'(1) : raw_idx;
    pick_mask = N_MOLES'(1) << pick_idx;
    mole_mask = N_MOLES'(1) << prev_idx;
    wrong     = |(press & ~mole_mask);
    hit       = |(press & mole_mask);
    timeout   = step_ev && (up_cnt == CNT_W'(UP_STEPS - 1));
  end

  // Game state machine with registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state     <= S_IDLE;
      led       <= '0;
      score     <= '0;
      lives     <= '0;
      active    <= 1'b0;
      game_over <= 1'b0;
      prev_idx  <= '0;
      up_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE, S_OVER: begin
          if (start_ev) begin
            score     <= '0;
            lives     <= 2'(LIVES);
            prev_idx  <= '0;
            led       <= '0;
            active    <= 1'b1;
            game_over <= 1'b0;
            state     <= S_GAP;
          end
        end
        S_GAP: begin
          if (step_ev) state <= S_PICK;
        end
        S_PICK: begin
          prev_idx <= pick_idx;
          up_cnt   <= '0;
          led      <= pick_mask;
          state    <= S_UP;
        end
        S_UP: begin
          if (wrong || (!hit && timeout)) begin
            lives <= lives - 2'd1;
            if (lives == 2'd1) begin
              led       <= '1;
              active    <= 1'b0;
              game_over <= 1'b1;
              state     <= S_OVER;
            end else begin
              led   <= '0;
              state <= S_GAP;
            end
          end else if (hit) begin
            if (score != 8'hFF) score <= score + 8'd1;
            led   <= '0;
            state <= S_GAP;
          end else if (step_ev) begin
            up_cnt <= up_cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mole_game_fsm.sv
// Self-checking bench for mole_game_fsm: behavioural game model compared every
// cycle, plus directed literal checks of the headline scenarios.
module tb_mole_game_fsm;

  localparam int unsigned N        = 4;
  localparam int unsigned UP_STEPS = 2;
  localparam int unsigned LIVES    = 3;
  localparam logic [7:0]  SEED     = 8'hA5;

  logic         clk_in;
  logic         rst;
  logic         step_clk;
  logic         start;
  logic [N-1:0] btn;
  logic [N-1:0] led;
  logic [7:0]   score;
  logic [1:0]   lives;
  logic         active;
  logic         game_over;

  int n_checks = 0;
  int n_errors = 0;
  bit checking = 0;

  mole_game_fsm #(
    .N_MOLES(N), .UP_STEPS(UP_STEPS), .LIVES(LIVES), .LFSR_SEED(SEED)
  ) dut (
    .clk_in(clk_in), .rst(rst), .step_clk(step_clk), .start(start), .btn(btn),
    .led(led), .score(score), .lives(lives), .active(active), .game_over(game_over)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Behavioural game model: events are raw samples delayed by 3 cycles.
  int         m_lit = -1;
  int         m_last = 0;
  int         m_steps_left = 0;
  int         m_score = 0;
  int         m_lives = 0;
  bit         m_pending = 0;
  bit         m_running = 0;
  bit         m_over = 0;
  logic [7:0] m_lfsr = SEED;
  logic         h_step [4];
  logic         h_start[4];
  logic [N-1:0] h_btn  [4];

  always @(posedge clk_in) begin : model_p
    logic         ev_step;
    logic         ev_start;
    logic [N-1:0] pr;
    logic [N-1:0] mask;
    int           idx;
    bit           miss;
    if (rst) begin
      m_lit = -1; m_last = 0; m_steps_left = 0; m_score = 0; m_lives = 0;
      m_pending = 0; m_running = 0; m_over = 0; m_lfsr = SEED;
      for (int i = 0; i < 4; i++) begin
        h_step[i] = 1'b0; h_start[i] = 1'b0; h_btn[i] = '0;
      end
    end else begin
      ev_step  = h_step[2] ^ h_step[3];
      ev_start = h_start[2] & ~h_start[3];
      pr       = h_btn[2] & ~h_btn[3];
      miss     = 0;
      if (!m_running) begin
        if (ev_start) begin
          m_score = 0; m_lives = LIVES; m_last = 0; m_running = 1; m_over = 0;
          m_lit = -1; m_pending = 0;
        end
      end else if (m_pending) begin
        idx = int'(m_lfsr) % N;
        if (idx == m_last) idx = (idx + 1) % N;
        m_last = idx; m_lit = idx; m_steps_left = UP_STEPS; m_pending = 0;
      end else if (m_lit < 0) begin
        if (ev_step) m_pending = 1;
      end else begin
        mask = N'(1) << m_lit;
        if ((pr & ~mask) != '0) miss = 1;
        else if (pr[m_lit]) begin
          if (m_score < 255) m_score = m_score + 1;
          m_lit = -1;
        end else if (ev_step) begin
          m_steps_left = m_steps_left - 1;
          if (m_steps_left == 0) miss = 1;
        end
      end
      if (miss) begin
        m_lives = m_lives - 1;
        m_lit = -1;
        if (m_lives == 0) begin m_running = 0; m_over = 1; end
      end
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      for (int i = 3; i > 0; i--) begin
        h_step[i] = h_step[i-1]; h_start[i] = h_start[i-1]; h_btn[i] = h_btn[i-1];
      end
      h_step[0] = step_clk; h_start[0] = start; h_btn[0] = btn;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [N-1:0] exp_led();
    if (m_over) return '1;
    if (m_lit >= 0) return N'(1) << m_lit;
    return '0;
  endfunction

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk_in) begin
    if (checking) begin
      check("led",       32'(led),       32'(exp_led()));
      check("score",     32'(score),     32'(m_score));
      check("lives",     32'(lives),     32'(m_lives));
      check("active",    32'(active),    32'(m_running));
      check("game_over", 32'(game_over), 32'(m_over));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(6); start = 1'b0; tick(6);
  endtask

  task automatic reset_dut();
    rst = 1'b1; tick(2); rst = 1'b0; tick(2);
  endtask

  task automatic begin_round();
    step_clk = ~step_clk; tick(5);
  endtask

  task automatic do_hit();
    int i;
    i = m_lit;
    if (i >= 0) btn[i] = 1'b1;
    tick(5); btn = '0; tick(5);
  endtask

  initial begin
    int i;
    int j;
    int prev;
    rst = 1'b1; start = 1'b0; btn = '0; step_clk = 1'b0;
    tick(1);
    checking = 1;
    tick(1);
    rst = 1'b0;

    // Idle: nothing happens without start, even with step_clk toggling.
    for (int c = 0; c < 50; c++) begin
      if (c % 6 == 0) step_clk = ~step_clk;
      tick(1);
      if (c % 10 == 9) begin
        check("idle_led", 32'(led), 32'h0);
        check("idle_score", 32'(score), 32'h0);
        check("idle_lives", 32'(lives), 32'h0);
        check("idle_active", 32'(active), 32'h0);
        check("idle_over", 32'(game_over), 32'h0);
      end
    end

    // Start and first pick timing.
    pulse_start();
    check("start_active", 32'(active), 32'h1);
    check("start_lives", 32'(lives), 32'h3);
    step_clk = ~step_clk;
    tick(4);
    check("led_dark_at4", 32'(led), 32'h0);
    tick(1);
    check("led_onehot_at5", 32'($onehot(led)), 32'h1);

    // Hit and held button.
    i = m_lit;
    btn[i] = 1'b1;
    tick(3);
    check("hit_score_at3", 32'(score), 32'h0);
    tick(1);
    check("hit_score_at4", 32'(score), 32'h1);
    check("hit_led_clear", 32'(led), 32'h0);
    tick(16);
    check("held_no_repeat", 32'(score), 32'h1);
    btn = '0; tick(6);

    // Consecutive rounds never relight the previous mole.
    for (int r = 0; r < 8; r++) begin
      prev = m_last;
      begin_round();
      check("onehot_round", 32'($onehot(led)), 32'h1);
      check("no_repeat_led", 32'(led != (N'(1) << prev)), 32'h1);
      do_hit();
    end

    // Randomised play against the model.
    for (int r = 0; r < 150; r++) begin
      if (!m_running) pulse_start();
      begin_round();
      i = m_lit;
      if (i < 0) i = 0;
      j = (i + 1 + int'($urandom_range(0, N - 2))) % N;
      case ($urandom_range(0, 4))
        0: begin tick(int'($urandom_range(0, 3))); btn[i] = 1'b1; tick(5); end
        1: begin btn[j] = 1'b1; tick(5); end
        2: begin btn[i] = 1'b1; btn[j] = 1'b1; tick(5); end
        3: begin
          repeat (UP_STEPS) begin step_clk = ~step_clk; tick(6); end
        end
        default: begin
          repeat (UP_STEPS - 1) begin step_clk = ~step_clk; tick(6); end
          step_clk = ~step_clk; btn[i] = 1'b1; tick(5);
        end
      endcase
      btn = '0;
      tick(6 + int'($urandom_range(0, 3)));
      if (m_running && $urandom_range(0, 9) == 0) pulse_start();
    end

    // Timeouts down to game over.
    reset_dut();
    pulse_start();
    for (int l = 0; l < LIVES; l++) begin
      step_clk = ~step_clk; tick(6);
      step_clk = ~step_clk; tick(6);
      if (l == 0) check("lit_after_step1", 32'($onehot(led)), 32'h1);
      step_clk = ~step_clk; tick(6);
      check("timeout_lives", 32'(lives), 32'(LIVES - 1 - l));
    end
    check("over_flag", 32'(game_over), 32'h1);
    check("over_led", 32'(led), 32'hF);
    check("over_score", 32'(score), 32'h0);
    check("over_active", 32'(active), 32'h0);

    // Simultaneous right+wrong press, then hit coinciding with final step.
    pulse_start();
    begin_round();
    i = m_lit;
    btn[i] = 1'b1; btn[(i + 1) % N] = 1'b1;
    tick(4);
    check("both_lives", 32'(lives), 32'h2);
    check("both_score", 32'(score), 32'h0);
    btn = '0; tick(6);
    begin_round();
    i = m_lit;
    step_clk = ~step_clk; tick(6);
    step_clk = ~step_clk; btn[i] = 1'b1;
    tick(5);
    check("tie_hit_score", 32'(score), 32'h1);
    check("tie_hit_lives", 32'(lives), 32'h2);
    btn = '0; tick(6);

    // Saturation, then reset in the middle of a round.
    reset_dut();
    pulse_start();
    for (int r = 0; r < 255; r++) begin
      begin_round();
      do_hit();
    end
    check("score_255", 32'(score), 32'hFF);
    begin_round();
    do_hit();
    check("score_sat", 32'(score), 32'hFF);
    begin_round();
    check("up_before_rst", 32'($onehot(led)), 32'h1);
    rst = 1'b1;
    tick(1);
    check("rst_led", 32'(led), 32'h0);
    check("rst_score", 32'(score), 32'h0);
    check("rst_lives", 32'(lives), 32'h0);
    check("rst_active", 32'(active), 32'h0);
    check("rst_over", 32'(game_over), 32'h0);
    rst = 1'b0;
    tick(5);

    checking = 0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
